// File: rtl/hs_chk_pkg.sv
// Shared types and helpers for the multi-channel req/gnt latency checker.
package hs_chk_pkg;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_EARLY   = 3'd1,
    ERR_TIMEOUT = 3'd2,
    ERR_OVERLAP = 3'd3,
    ERR_SPUR    = 3'd4
  } err_code_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } chan_state_e;

  // Increments are at most NUM_CH per cycle, so the 64-bit sum cannot overflow.
  function automatic longint unsigned sat_add(input longint unsigned acc,
                                              input longint unsigned inc,
                                              input longint unsigned max_val);
    longint unsigned sum;
    sum = acc + inc;
    return (sum > max_val) ? max_val : sum;
  endfunction

endpackage

// File: rtl/hs_chk_if.sv
// Monitored req/gnt bundle plus the checker's status outputs.
interface hs_chk_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0]   req;
  logic [NUM_CH-1:0]   gnt;
  logic [NUM_CH-1:0]   pass;
  logic [NUM_CH-1:0]   err;
  logic [3*NUM_CH-1:0] err_code;
  logic [NUM_CH-1:0]   err_sticky;
  logic [CNT_W-1:0]    pass_total;
  logic [CNT_W-1:0]    err_total;

  modport master (output req, gnt,
                  input  pass, err, err_code, err_sticky, pass_total, err_total);
  modport slave  (input  req, gnt,
                  output pass, err, err_code, err_sticky, pass_total, err_total);
endinterface

// File: rtl/hs_chk_chan.sv
// One req/gnt channel: IDLE/WAIT FSM with latency counter and registered verdicts.
// With HS_CHK_STATS_EN defined, also exports the latency of the current pass pulse.
module hs_chk_chan
  import hs_chk_pkg::*;
#(
  parameter int MIN_LAT = 3,
  parameter int MAX_LAT = 3,
  parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_enable,
  input  logic      i_req,
  input  logic      i_gnt,
  output logic      o_pass,
  output logic      o_err,
  output err_code_e o_err_code
`ifdef HS_CHK_STATS_EN
  ,
  output logic [LAT_W-1:0] o_pass_lat
`endif
);

  localparam logic [LAT_W-1:0] LAT_MIN = LAT_W'(MIN_LAT);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);

  chan_state_e      r_state, w_state_nxt;
  logic [LAT_W-1:0] r_lat, w_lat_nxt;
  logic             w_pass_nxt, w_err_nxt, w_done;
  err_code_e        w_code_nxt;

  // A check completes on a grant or when the window closes without one.
  assign w_done = (r_state == WAIT) && (i_gnt || (r_lat == LAT_MAX));

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lat   <= w_lat_nxt;
    end
  end

  // NOTE: defaults first in every always_comb so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat;
    if (!i_enable) begin
      w_state_nxt = IDLE;
      w_lat_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = i_req ? WAIT : IDLE;
          w_lat_nxt   = i_req ? LAT_W'(1) : '0;
        end
        WAIT: begin
          if (w_done) begin
            w_state_nxt = i_req ? WAIT : IDLE;
            w_lat_nxt   = i_req ? LAT_W'(1) : '0;
          end else begin
            w_lat_nxt   = r_lat + LAT_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_lat_nxt   = '0;
        end
      endcase
    end
  end

  // Branch order gives EARLY > TIMEOUT > OVERLAP; SPUR only arises in IDLE.
  always_comb begin
    w_pass_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    w_code_nxt = ERR_NONE;
    if (i_enable) begin
      case (r_state)
        IDLE: begin
          if (i_gnt) begin
            w_err_nxt  = 1'b1;
            w_code_nxt = ERR_SPUR;
          end
        end
        WAIT: begin
          if (i_gnt) begin
            if (r_lat < LAT_MIN) begin
              w_err_nxt  = 1'b1;
              w_code_nxt = ERR_EARLY;
            end else begin
              w_pass_nxt = 1'b1;
            end
          end else if (r_lat == LAT_MAX) begin
            w_err_nxt  = 1'b1;
            w_code_nxt = ERR_TIMEOUT;
          end else if (i_req) begin
            w_err_nxt  = 1'b1;
            w_code_nxt = ERR_OVERLAP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_pass     <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= ERR_NONE;
`ifdef HS_CHK_STATS_EN
      o_pass_lat <= '0;
`endif
    end else begin
      o_pass <= w_pass_nxt;
      o_err  <= w_err_nxt;
      if (w_err_nxt) o_err_code <= w_code_nxt;
`ifdef HS_CHK_STATS_EN
      if (w_pass_nxt) o_pass_lat <= r_lat;
`endif
    end
  end

endmodule

// File: rtl/hs_latency_checker.sv
// Multi-channel req/gnt latency-window checker: per-channel FSMs, sticky errors, saturating totals.
// Optional HS_CHK_STATS_EN adds lat_max, the largest passing latency per channel.
module hs_latency_checker
  import hs_chk_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int MIN_LAT = 3,
  parameter int MAX_LAT = 3,
  parameter int CNT_W   = 16
) (
  input logic     clk,
  input logic     rst_n,
  input logic     enable,
  input logic     clr,
  hs_chk_if.slave bus
`ifdef HS_CHK_STATS_EN
  ,
  output logic [NUM_CH*$clog2(MAX_LAT+1)-1:0] lat_max
`endif
);

  localparam int              LAT_W   = $clog2(MAX_LAT + 1);
  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if (MIN_LAT < 1 || MAX_LAT < MIN_LAT) begin : g_bad_param
    $error("hs_latency_checker: parameters must satisfy 1 <= MIN_LAT <= MAX_LAT");
  end

  logic [NUM_CH-1:0] w_pass, w_err;
  err_code_e         w_code [NUM_CH];
  logic [NUM_CH-1:0] r_err_sticky;
  logic [CNT_W-1:0]  r_pass_total, r_err_total;
`ifdef HS_CHK_STATS_EN
  logic [LAT_W-1:0]  w_pass_lat [NUM_CH];
  logic [LAT_W-1:0]  r_lat_max  [NUM_CH];
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    hs_chk_chan #(
      .MIN_LAT(MIN_LAT),
      .MAX_LAT(MAX_LAT),
      .LAT_W  (LAT_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_enable  (enable),
      .i_req     (bus.req[g]),
      .i_gnt     (bus.gnt[g]),
      .o_pass    (w_pass[g]),
      .o_err     (w_err[g]),
      .o_err_code(w_code[g])
`ifdef HS_CHK_STATS_EN
      ,
      .o_pass_lat(w_pass_lat[g])
`endif
    );
    assign bus.err_code[3*g +: 3] = w_code[g];
  end

  // Totals count the visible pulses, so they trail pass/err by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sticky <= '0;
      r_pass_total <= '0;
      r_err_total  <= '0;
    end else if (clr) begin
      r_err_sticky <= '0;
      r_pass_total <= '0;
      r_err_total  <= '0;
    end else begin
      r_err_sticky <= r_err_sticky | w_err;
      r_pass_total <= CNT_W'(sat_add(64'(r_pass_total), 64'($countones(w_pass)), CNT_MAX));
      r_err_total  <= CNT_W'(sat_add(64'(r_err_total), 64'($countones(w_err)), CNT_MAX));
    end
  end

  assign bus.pass       = w_pass;
  assign bus.err        = w_err;
  assign bus.err_sticky = r_err_sticky;
  assign bus.pass_total = r_pass_total;
  assign bus.err_total  = r_err_total;

`ifdef HS_CHK_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) r_lat_max[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr) r_lat_max[i] <= '0;
        else if (w_pass[i] && (w_pass_lat[i] > r_lat_max[i])) r_lat_max[i] <= w_pass_lat[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lat_max
    assign lat_max[g*LAT_W +: LAT_W] = r_lat_max[g];
  end
`endif

endmodule

// File: tb/tb_hs_latency_checker.sv
// Directed bench: default, wide-window (2..5) and 2-bit-counter checker instances.
module tb_hs_latency_checker;
  import hs_chk_pkg::*;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [3:0]  exp_pass;
    logic [3:0]  exp_err;
    logic [11:0] exp_code;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_def = 1'b1, en_win = 1'b1, en_sat = 1'b1;
  logic clr_def = 1'b0, clr_win = 1'b0, clr_sat = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hs_chk_if #(.NUM_CH(4), .CNT_W(16)) if_def ();
  hs_chk_if #(.NUM_CH(4), .CNT_W(16)) if_win ();
  hs_chk_if #(.NUM_CH(4), .CNT_W(2))  if_sat ();

`ifdef HS_CHK_STATS_EN
  logic [7:0]  lat_max_def;
  logic [11:0] lat_max_win;
  logic [7:0]  lat_max_sat;
`endif

  hs_latency_checker #(.NUM_CH(4), .MIN_LAT(3), .MAX_LAT(3), .CNT_W(16)) u_def (
    .clk(clk), .rst_n(rst_n), .enable(en_def), .clr(clr_def), .bus(if_def)
`ifdef HS_CHK_STATS_EN
    , .lat_max(lat_max_def)
`endif
  );

  hs_latency_checker #(.NUM_CH(4), .MIN_LAT(2), .MAX_LAT(5), .CNT_W(16)) u_win (
    .clk(clk), .rst_n(rst_n), .enable(en_win), .clr(clr_win), .bus(if_win)
`ifdef HS_CHK_STATS_EN
    , .lat_max(lat_max_win)
`endif
  );

  hs_latency_checker #(.NUM_CH(4), .MIN_LAT(3), .MAX_LAT(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(en_sat), .clr(clr_sat), .bus(if_sat)
`ifdef HS_CHK_STATS_EN
    , .lat_max(lat_max_sat)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Inputs set before calling step() are sampled at the next edge; outputs are read 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] cv(input err_code_e c3, input err_code_e c2,
                                     input err_code_e c1, input err_code_e c0);
    return {c3, c2, c1, c0};
  endfunction

  task automatic apply_row(input int dut, input int idx, input vec_t v);
    logic [3:0]  a_pass, a_err;
    logic [11:0] a_code;
    string       tag;
    if (dut == 0) begin
      if_def.req = v.req; if_def.gnt = v.gnt;
    end else begin
      if_win.req = v.req; if_win.gnt = v.gnt;
    end
    step();
    if (dut == 0) begin
      a_pass = if_def.pass; a_err = if_def.err; a_code = if_def.err_code; tag = "def";
    end else begin
      a_pass = if_win.pass; a_err = if_win.err; a_code = if_win.err_code; tag = "win";
    end
    check($sformatf("%s[%0d].pass", tag, idx), 64'(a_pass), 64'(v.exp_pass));
    check($sformatf("%s[%0d].err", tag, idx), 64'(a_err), 64'(v.exp_err));
    check($sformatf("%s[%0d].err_code", tag, idx), 64'(a_code), 64'(v.exp_code));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t def_tab[10];
    vec_t win_tab[7];

    // Default window 3..3: ch0 pass, ch1 early then timeout, ch2 spurious, ch3 back-to-back.
    def_tab[0] = '{4'b1011, 4'b0000, 4'b0000, 4'b0000, cv(ERR_NONE, ERR_NONE, ERR_NONE, ERR_NONE)};
    def_tab[1] = '{4'b0000, 4'b0100, 4'b0000, 4'b0100, cv(ERR_NONE, ERR_SPUR, ERR_NONE, ERR_NONE)};
    def_tab[2] = '{4'b0000, 4'b0010, 4'b0000, 4'b0010, cv(ERR_NONE, ERR_SPUR, ERR_EARLY, ERR_NONE)};
    def_tab[3] = '{4'b1000, 4'b1001, 4'b1001, 4'b0000, cv(ERR_NONE, ERR_SPUR, ERR_EARLY, ERR_NONE)};
    def_tab[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, cv(ERR_NONE, ERR_SPUR, ERR_EARLY, ERR_NONE)};
    def_tab[5] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, cv(ERR_NONE, ERR_SPUR, ERR_EARLY, ERR_NONE)};
    def_tab[6] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, cv(ERR_NONE, ERR_SPUR, ERR_EARLY, ERR_NONE)};
    def_tab[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, cv(ERR_NONE, ERR_SPUR, ERR_EARLY, ERR_NONE)};
    def_tab[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, cv(ERR_NONE, ERR_SPUR, ERR_TIMEOUT, ERR_NONE)};
    def_tab[9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, cv(ERR_NONE, ERR_SPUR, ERR_TIMEOUT, ERR_NONE)};

    // Window 2..5: ch0 early+re-request then pass at 2, ch1 pass at 5, ch2 overlap then pass at 4, ch3 timeout.
    win_tab[0] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, cv(ERR_NONE, ERR_NONE, ERR_NONE, ERR_NONE)};
    win_tab[1] = '{4'b0101, 4'b0001, 4'b0000, 4'b0101, cv(ERR_NONE, ERR_OVERLAP, ERR_NONE, ERR_EARLY)};
    win_tab[2] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, cv(ERR_NONE, ERR_OVERLAP, ERR_NONE, ERR_EARLY)};
    win_tab[3] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, cv(ERR_NONE, ERR_OVERLAP, ERR_NONE, ERR_EARLY)};
    win_tab[4] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, cv(ERR_NONE, ERR_OVERLAP, ERR_NONE, ERR_EARLY)};
    win_tab[5] = '{4'b0000, 4'b0010, 4'b0010, 4'b1000, cv(ERR_TIMEOUT, ERR_OVERLAP, ERR_NONE, ERR_EARLY)};
    win_tab[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, cv(ERR_TIMEOUT, ERR_OVERLAP, ERR_NONE, ERR_EARLY)};

    if_def.req = '0; if_def.gnt = '0;
    if_win.req = '0; if_win.gnt = '0;
    if_sat.req = '0; if_sat.gnt = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst.pass", 64'(if_def.pass), 64'd0);
    check("rst.err", 64'(if_def.err), 64'd0);
    check("rst.err_code", 64'(if_def.err_code), 64'd0);
    check("rst.err_sticky", 64'(if_def.err_sticky), 64'd0);
    check("rst.pass_total", 64'(if_def.pass_total), 64'd0);
    check("rst.err_total", 64'(if_def.err_total), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) apply_row(0, i, def_tab[i]);
    if_def.req = '0; if_def.gnt = '0;
    check("def.pass_total", 64'(if_def.pass_total), 64'd3);
    check("def.err_total", 64'(if_def.err_total), 64'd3);
    check("def.err_sticky", 64'(if_def.err_sticky), 64'b0110);

    for (int i = 0; i < 7; i++) apply_row(1, i, win_tab[i]);
    if_win.req = '0; if_win.gnt = '0;
    check("win.pass_total", 64'(if_win.pass_total), 64'd3);
    check("win.err_total", 64'(if_win.err_total), 64'd3);
`ifdef HS_CHK_STATS_EN
    check("win.lat_max", 64'(lat_max_win), 64'({3'd0, 3'd4, 3'd5, 3'd2}));
`endif

    // enable=0 drops the pending ch0 check, so the later grant is spurious.
    if_win.req = 4'b0001; step();
    if_win.req = '0; en_win = 1'b0; if_win.gnt = 4'b0001; step();
    check("win.dis.err", 64'(if_win.err), 64'd0);
    check("win.dis.pass", 64'(if_win.pass), 64'd0);
    en_win = 1'b1; step();
    check("win.reen.err", 64'(if_win.err), 64'b0001);
    check("win.reen.pass", 64'(if_win.pass), 64'd0);
    check("win.reen.code0", 64'(if_win.err_code[2:0]), 64'(ERR_SPUR));
    if_win.gnt = '0; step();

    // 2-bit totals: four passes then a fifth must stick at 3; clr beats a pending err pulse.
    if_sat.req = 4'b1111; step();
    if_sat.req = '0; step(); step();
    if_sat.req = 4'b0001; if_sat.gnt = 4'b1111; step();
    check("sat.pass4", 64'(if_sat.pass), 64'b1111);
    if_sat.req = '0; if_sat.gnt = '0; step();
    check("sat.total_after4", 64'(if_sat.pass_total), 64'd3);
    step();
    if_sat.gnt = 4'b0001; step();
    check("sat.pass5", 64'(if_sat.pass), 64'b0001);
    if_sat.gnt = 4'b0010; step();
    check("sat.total_after5", 64'(if_sat.pass_total), 64'd3);
    check("sat.spur1", 64'(if_sat.err), 64'b0010);
    if_sat.gnt = 4'b0100; step();
    check("sat.err_total", 64'(if_sat.err_total), 64'd1);
    check("sat.sticky", 64'(if_sat.err_sticky), 64'b0010);
    check("sat.spur2", 64'(if_sat.err), 64'b0100);
    if_sat.gnt = '0; clr_sat = 1'b1; step();
    check("clr.pass_total", 64'(if_sat.pass_total), 64'd0);
    check("clr.err_total", 64'(if_sat.err_total), 64'd0);
    check("clr.sticky", 64'(if_sat.err_sticky), 64'd0);
    clr_sat = 1'b0; step();
    check("clr.hold.err_total", 64'(if_sat.err_total), 64'd0);
    check("clr.hold.sticky", 64'(if_sat.err_sticky), 64'd0);

    // Asynchronous reset mid-WAIT on ch0 of the default instance.
    if_def.req = 4'b0001; step();
    if_def.req = '0; step();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.pass_total", 64'(if_def.pass_total), 64'd0);
    check("arst.err_total", 64'(if_def.err_total), 64'd0);
    check("arst.err_sticky", 64'(if_def.err_sticky), 64'd0);
    check("arst.err_code", 64'(if_def.err_code), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("arst.quiet[%0d]", i), 64'(if_def.err), 64'd0);
    end
    if_def.req = 4'b0001; step();
    if_def.req = '0; step(); step();
    if_def.gnt = 4'b0001; step();
    check("arst.new.pass", 64'(if_def.pass), 64'b0001);
    check("arst.new.err", 64'(if_def.err), 64'd0);
    if_def.gnt = '0; step();
    check("arst.new.pass_total", 64'(if_def.pass_total), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hs_latency_checker.md
Name: hs_latency_checker

Overview:
- Synthesizable, multi-channel req/gnt handshake protocol checker; next generation of the single fixed-latency `req |=> ##2 gnt` check.
- Each channel checks that a grant arrives within a parametrised latency window [MIN_LAT, MAX_LAT] after its request.
- Reports per-channel pass/error pulses, error codes, sticky status and saturating totals.
- Sits passively beside any requester/granter pair; drives nothing in the datapath.

Parameters:
- NUM_CH, 4, number of independent req/gnt channels (>=1).
- MIN_LAT, 3, earliest legal grant, in cycles after the request edge.
- MAX_LAT, 3, latest legal grant (>=MIN_LAT).
- CNT_W, 16, width of the saturating pass/error totals.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  checking enable; 0 forces all channels IDLE, counters hold
- clr  input  1  synchronous clear of err_sticky and both totals
- req  input  NUM_CH  per-channel request, sampled at posedge clk
- gnt  input  NUM_CH  per-channel grant, sampled at posedge clk
- pass  output  NUM_CH  one-cycle pulse: legal grant observed
- err  output  NUM_CH  one-cycle pulse: violation observed
- err_code  output  3*NUM_CH  code of last violation per channel (package enum)
- err_sticky  output  NUM_CH  set by err, cleared by clr
- pass_total  output  CNT_W  saturating count of pass pulses
- err_total  output  CNT_W  saturating count of err pulses

Behaviour:
- Reset (rst_n=0, asynchronous): all channels IDLE; all outputs 0; err_code=ERR_NONE.
- Parameter legality: elaboration $error if MIN_LAT<1 or MAX_LAT<MIN_LAT.
- Per-channel FSM, states IDLE and WAIT; latency counter lat of width $clog2(MAX_LAT+1).
- Request at sample edge t:
  - IDLE with req=1 → WAIT, lat=1 at edge t+1.
  - In WAIT, lat increments each edge; a grant sampled at edge t+k is seen with lat=k.
- WAIT with gnt=1:
  - lat<MIN_LAT → err, ERR_EARLY, → IDLE.
  - MIN_LAT<=lat<=MAX_LAT → pass, → IDLE.
- WAIT with gnt=0 and lat==MAX_LAT → err, ERR_TIMEOUT, → IDLE.
- IDLE with gnt=1 → err, ERR_SPUR.
  - If req=1 on the same edge, req is also accepted → WAIT.
- WAIT with req=1:
  - On the edge that completes with pass or any error → new request accepted, → WAIT with lat=1 (back-to-back).
  - On any other edge → err, ERR_OVERLAP; req ignored; lat keeps counting.
- Simultaneous overlap and EARLY on one edge: EARLY reported (precedence EARLY > TIMEOUT > OVERLAP > SPUR); at most one err pulse per channel per cycle.
- pass/err are registered: they pulse in the cycle after the deciding edge.
  - Defaults MIN=MAX=3: req at edge 0, gnt at edge 3 → pass high during cycle after edge 3.
- err_code updates only when err fires and holds otherwise.
- Totals:
  - Each cycle, add popcount(pass) to pass_total and popcount(err) to err_total.
  - Saturate at 2^CNT_W-1; never wrap.
  - clr has priority over a same-cycle increment; clr does not affect the FSMs.
- enable=0: FSMs forced IDLE next edge; no pass/err generated; sticky and totals hold.
- Reset mid-transaction: pending checks discarded silently; no err generated.

Optional Feature:
- Macro HS_CHK_STATS_EN.
- Defined: adds output lat_max (NUM_CH*$clog2(MAX_LAT+1)), the per-channel largest latency among passing handshakes.
  - Reset to 0; cleared by clr; updated on pass when lat exceeds the stored value.
- Undefined: port and registers absent; all other behaviour identical.

Decomposition:
- Package hs_chk_pkg:
  - err_code_e (3-bit): ERR_NONE=0, ERR_EARLY=1, ERR_TIMEOUT=2, ERR_OVERLAP=3, ERR_SPUR=4.
  - chan_state_e: IDLE, WAIT.
  - Helper function for saturating add.
- Sub-module hs_chk_chan:
  - One FSM, latency counter and pass/err/err_code registers.
  - Instantiated NUM_CH times in a generate loop.
- Top level: totals, sticky bits, optional stats.

Test Plan:
- Defaults; ch0 req pulse at edge 0, gnt at edge 3 → pass[0]=1 for one cycle, pass_total=1, err_total=0.
- Defaults; ch1 req edge 0, gnt edge 2 → err[1]=1, err_code[1]=ERR_EARLY, err_sticky[1]=1; then gnt absent after a new req edge 5 → err at edge 8 with ERR_TIMEOUT, err_total=2.
- MIN_LAT=2, MAX_LAT=5; ch2 req edge 0, req again edge 1, gnt edge 4 → ERR_OVERLAP pulse after edge 1, then pass after edge 4.
- Back-to-back on ch3: req at edges 0 and 3, gnt at edges 3 and 6 → two passes, no err.
- IDLE gnt with no req → ERR_SPUR.
- CNT_W=2: drive 5 passes → pass_total saturates at 3; assert clr → totals and err_sticky become 0 next cycle.
- Reset: deassert rst_n asynchronously between clock edges, mid-WAIT → all outputs 0 immediately; no err after release; a new req/gnt at latency 3 → pass.
